// File: rtl/servo_pkg.sv
// Shared types and timing defaults for the servo tester PWM generator/decoder.
package servo_pkg;

    localparam int unsigned CNT_W   = 21;
    localparam int unsigned POS_W   = 8;
    localparam int unsigned POS_MAX = (1 << POS_W) - 1;

    // Default timing at 10 MHz, shared with the PWM generator
    localparam int unsigned DEF_BASE_CYC      = 10000;
    localparam int unsigned DEF_STEP_CYC      = 39;
    localparam int unsigned DEF_MIN_PULSE_CYC = 5000;
    localparam int unsigned DEF_MAX_PULSE_CYC = 30000;
    localparam int unsigned DEF_TIMEOUT_CYC   = 250000;

    // Synchronizer flops reset high so a line that is already high is not seen as a rise
    localparam logic SYNC_RST_LVL = 1'b1;

    typedef enum logic [2:0] {
        ST_WAIT_LOW = 3'd0,
        ST_IDLE     = 3'd1,
        ST_BASE     = 3'd2,
        ST_STEP     = 3'd3,
        ST_OVERLONG = 3'd4
    } state_e;

    // Position increment that sticks at full scale
    function automatic logic [POS_W-1:0] pos_sat_inc(input logic [POS_W-1:0] p);
        return (p == POS_W'(POS_MAX)) ? p : p + POS_W'(1);
    endfunction

endpackage

// File: rtl/servo_in_sync.sv
// PWM input conditioning: 2-FF synchronizer, optional majority-of-3 glitch
// filter (PWM_GLITCH_FILTER_EN), registered level plus rise/fall strobes.
module servo_in_sync
    import servo_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic ena_i,
    input  logic pwm_i,
    output logic s_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic s_d;

`ifdef PWM_GLITCH_FILTER_EN
    logic hist1_q;
    logic hist2_q;

    // Majority over the three most recent synchronized samples
    always_comb begin
        s_d = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
    end

    // Sample history for the filter
    always_ff @(posedge clk) begin
        if (reset) begin
            hist1_q <= SYNC_RST_LVL;
            hist2_q <= SYNC_RST_LVL;
        end else if (ena_i) begin
            hist1_q <= sync2_q;
            hist2_q <= hist1_q;
        end
    end
`else
    // Unfiltered path
    always_comb begin
        s_d = sync2_q;
    end
`endif

    // Synchronizer, level register and edge strobes (edges compare new vs held level)
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= SYNC_RST_LVL;
            sync2_q <= SYNC_RST_LVL;
            s_o     <= SYNC_RST_LVL;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
        end else if (ena_i) begin
            sync1_q <= pwm_i;
            sync2_q <= sync1_q;
            s_o     <= s_d;
            rise_o  <= s_d & ~s_o;
            fall_o  <= ~s_d & s_o;
        end
    end

endmodule

// File: rtl/servo_pwm_decoder.sv
// RC-servo PWM decoder: measures pulse high time and converts it to an 8-bit
// position, flagging short, overlong and missing pulses.
// Optional macro PWM_GLITCH_FILTER_EN enables the input glitch filter.
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter int unsigned BASE_CYC      = DEF_BASE_CYC,
    parameter int unsigned STEP_CYC      = DEF_STEP_CYC,
    parameter int unsigned MIN_PULSE_CYC = DEF_MIN_PULSE_CYC,
    parameter int unsigned MAX_PULSE_CYC = DEF_MAX_PULSE_CYC,
    parameter int unsigned TIMEOUT_CYC   = DEF_TIMEOUT_CYC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             pwm_in,
    output logic [POS_W-1:0] pos,
    output logic             pos_valid,
    output logic             err_short,
    output logic             err_long,
    output logic             signal_lost,
    output logic             busy
);

    localparam logic [CNT_W-1:0] BASE_LAST = CNT_W'(BASE_CYC - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_W     = CNT_W'(MIN_PULSE_CYC);
    localparam logic [CNT_W-1:0] MAX_W     = CNT_W'(MAX_PULSE_CYC);
    localparam logic [CNT_W-1:0] TO_W      = CNT_W'(TIMEOUT_CYC);

    logic s;
    logic rise;
    logic fall;

    state_e state_q, state_d;

    logic [CNT_W-1:0] w_q, w_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [POS_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] to_q, to_d;

    logic [POS_W-1:0] pos_q, pos_d;
    logic             pos_valid_q, pos_valid_d;
    logic             err_short_q, err_short_d;
    logic             err_long_q, err_long_d;
    logic             lost_q, lost_d;
    logic             busy_q, busy_d;

    servo_in_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .ena_i  (ena),
        .pwm_i  (pwm_in),
        .s_o    (s),
        .rise_o (rise),
        .fall_o (fall)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_WAIT_LOW;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; overlong check wins over the BASE->STEP handover
    always_comb begin
        state_d = state_q;
        if (ena) begin
            case (state_q)
                ST_WAIT_LOW: if (!s) state_d = ST_IDLE;
                ST_IDLE:     if (rise) state_d = ST_BASE;
                ST_BASE: begin
                    if (fall)                 state_d = ST_IDLE;
                    else if (w_q >= MAX_W)    state_d = ST_OVERLONG;
                    else if (w_q == BASE_LAST) state_d = ST_STEP;
                end
                ST_STEP: begin
                    if (fall)              state_d = ST_IDLE;
                    else if (w_q >= MAX_W) state_d = ST_OVERLONG;
                end
                ST_OVERLONG: if (!s) state_d = ST_IDLE;
                default:     state_d = ST_WAIT_LOW;
            endcase
        end
    end

    // Width counter, step prescaler, position accumulator and timeout counter
    always_comb begin
        w_d     = w_q;
        presc_d = presc_q;
        acc_d   = acc_q;
        to_d    = to_q;
        if (ena) begin
            if (rise) begin
                to_d = '0;
            end else if (to_q < TO_W) begin
                to_d = to_q + CNT_W'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        w_d     = CNT_W'(1);
                        presc_d = '0;
                        acc_d   = '0;
                    end
                end
                ST_BASE: begin
                    if (!fall) w_d = w_q + CNT_W'(1);
                end
                ST_STEP: begin
                    if (!fall) begin
                        w_d = w_q + CNT_W'(1);
                        if (presc_q == STEP_LAST) begin
                            presc_d = '0;
                            acc_d   = pos_sat_inc(acc_q);
                        end else begin
                            presc_d = presc_q + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Output next values: measurement result on fall, overlong on entry, loss on timeout
    always_comb begin
        pos_d       = pos_q;
        pos_valid_d = 1'b0;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        lost_d      = lost_q;
        busy_d      = (state_d == ST_BASE) || (state_d == ST_STEP);
        if (ena) begin
            if (to_d >= TO_W) lost_d = 1'b1;
            if (((state_q == ST_BASE) || (state_q == ST_STEP)) && fall) begin
                if (w_q < MIN_W) begin
                    err_short_d = 1'b1;
                end else begin
                    pos_valid_d = 1'b1;
                    lost_d      = 1'b0;
                    pos_d       = (state_q == ST_STEP) ? acc_q : '0;
                end
            end
            if ((state_d == ST_OVERLONG) && (state_q != ST_OVERLONG)) err_long_d = 1'b1;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            w_q         <= '0;
            presc_q     <= '0;
            acc_q       <= '0;
            to_q        <= '0;
            pos_q       <= '0;
            pos_valid_q <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            lost_q      <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            w_q         <= w_d;
            presc_q     <= presc_d;
            acc_q       <= acc_d;
            to_q        <= to_d;
            pos_q       <= pos_d;
            pos_valid_q <= pos_valid_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            lost_q      <= lost_d;
            busy_q      <= busy_d;
        end
    end

    assign pos         = pos_q;
    assign pos_valid   = pos_valid_q;
    assign err_short   = err_short_q;
    assign err_long    = err_long_q;
    assign signal_lost = lost_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Self-checking bench for servo_pwm_decoder with scaled-down timing parameters.
module tb_servo_pwm_decoder;

    localparam int T_BASE = 200;
    localparam int T_STEP = 4;
    localparam int T_MIN  = 100;
    localparam int T_MAX  = 1400;
    localparam int T_TO   = 3000;
`ifdef PWM_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       ena;
    logic       pwm_in;
    logic [7:0] pos;
    logic       pos_valid;
    logic       err_short;
    logic       err_long;
    logic       signal_lost;
    logic       busy;

    servo_pwm_decoder #(
        .BASE_CYC      (T_BASE),
        .STEP_CYC      (T_STEP),
        .MIN_PULSE_CYC (T_MIN),
        .MAX_PULSE_CYC (T_MAX),
        .TIMEOUT_CYC   (T_TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ena         (ena),
        .pwm_in      (pwm_in),
        .pos         (pos),
        .pos_valid   (pos_valid),
        .err_short   (err_short),
        .err_long    (err_long),
        .signal_lost (signal_lost),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge
    int v_cnt = 0, s_cnt = 0, l_cnt = 0, v_cyc = 0;
    always @(negedge clk) begin
        if (pos_valid) begin
            v_cnt = v_cnt + 1;
            v_cyc = cyc;
        end
        if (err_short) s_cnt = s_cnt + 1;
        if (err_long)  l_cnt = l_cnt + 1;
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1);
    end

    int   n_cmp = 0, n_bad = 0;
    int   model_pos = 0;
    bit   model_lost = 1'b1;
    int   rise_cyc = 0, fall_cyc = 0;
    int   v0 = 0, s0 = 0, l0 = 0;
    logic probe_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: position from high time by plain arithmetic
    function automatic int ref_pos(input int w);
        int p;
        if (w < T_BASE) return 0;
        p = (w - T_BASE) / T_STEP;
        return (p > 255) ? 255 : p;
    endfunction

    task automatic snap();
        v0 = v_cnt;
        s0 = s_cnt;
        l0 = l_cnt;
    endtask

    task automatic pulse(input int w, input int probe);
        @(negedge clk);
        pwm_in   = 1'b1;
        rise_cyc = cyc;
        probe_busy = 1'bx;
        for (int i = 0; i < w; i++) begin
            @(negedge clk);
            if (i == probe) probe_busy = busy;
        end
        pwm_in   = 1'b0;
        fall_cyc = cyc;
        repeat (LAT + 6) @(negedge clk);
    endtask

    task automatic check_result(input int w, input string tag);
        bit ok;
        ok = (w >= T_MIN) && (w <= T_MAX);
        if (ok) begin
            model_pos  = ref_pos(w);
            model_lost = 1'b0;
        end
        check({tag, ".valid_cnt"}, 32'(v_cnt - v0), 32'(ok));
        check({tag, ".short_cnt"}, 32'(s_cnt - s0), 32'(w < T_MIN));
        check({tag, ".long_cnt"},  32'(l_cnt - l0), 32'(w > T_MAX));
        check({tag, ".pos"},       32'(pos), 32'(model_pos));
        check({tag, ".lost"},      32'(signal_lost), 32'(model_lost));
        check({tag, ".busy_after"}, 32'(busy), 32'(0));
        if (ok) check({tag, ".latency"}, 32'(v_cyc - fall_cyc), 32'(LAT));
    endtask

    task automatic run(input int w, input string tag);
        snap();
        pulse(w, w / 2);
        if (w >= 16) check({tag, ".busy_mid"}, 32'(probe_busy), 32'(1));
        check_result(w, tag);
    endtask

    initial begin
        reset  = 1'b1;
        ena    = 1'b1;
        pwm_in = 1'b0;
        repeat (5) @(negedge clk);
        check("rst.pos",       32'(pos), 32'(0));
        check("rst.pos_valid", 32'(pos_valid), 32'(0));
        check("rst.err_short", 32'(err_short), 32'(0));
        check("rst.err_long",  32'(err_long), 32'(0));
        check("rst.lost",      32'(signal_lost), 32'(1));
        check("rst.busy",      32'(busy), 32'(0));
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Directed boundary pulses
        run(T_BASE,                 "w_base");
        run(T_BASE + T_STEP * 128,  "w_128");
        run(T_BASE + T_STEP * 128 - 1, "w_127");
        run(1300,                   "w_sat");
        run(T_BASE + T_STEP * 255,  "w_255");
        run(T_BASE + T_STEP * 255 - 1, "w_254");
        run(140,                    "w_below_base");
        run(80,                     "w_short");
        run(T_MIN - 1,              "w_min_m1");
        run(T_MIN,                  "w_min");
        run(T_MAX,                  "w_max");
        run(T_MAX + 1,              "w_max_p1");

        // Overlong pulse: busy must drop once err_long fires
        snap();
        pulse(1600, T_MAX + 10);
        check("overlong.busy_late", 32'(probe_busy), 32'(0));
        check_result(1600, "overlong");
        run(440, "after_overlong");

        // ena low while idle: nothing moves
        snap();
        ena = 1'b0;
        repeat (20) @(negedge clk);
        check("ena_idle.pos",  32'(pos), 32'(model_pos));
        check("ena_idle.busy", 32'(busy), 32'(0));
        check("ena_idle.strobes", 32'((v_cnt - v0) + (s_cnt - s0) + (l_cnt - l0)), 32'(0));
        ena = 1'b1;

        // ena low inside a pulse: only enabled cycles are measured
        snap();
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (200) @(negedge clk);
        ena = 1'b0;
        repeat (30) @(negedge clk);
        check("ena_mid.busy_held", 32'(busy), 32'(1));
        ena = 1'b1;
        repeat (270) @(negedge clk);
        pwm_in   = 1'b0;
        fall_cyc = cyc;
        repeat (LAT + 6) @(negedge clk);
        check_result(470, "ena_mid");

        // Timeout: no edges after a valid pulse
        run(600, "pre_timeout");
        while (cyc < rise_cyc + T_TO - 100) @(negedge clk);
        check("timeout.before", 32'(signal_lost), 32'(0));
        while (cyc < rise_cyc + T_TO + 100) @(negedge clk);
        model_lost = 1'b1;
        check("timeout.lost", 32'(signal_lost), 32'(1));
        check("timeout.pos_hold", 32'(pos), 32'(model_pos));
        run(400, "after_timeout");

        // Reset in the middle of a pulse; the remainder must be ignored
        snap();
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (160) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        model_pos  = 0;
        model_lost = 1'b1;
        check("midrst.pos",  32'(pos), 32'(0));
        check("midrst.pos_valid", 32'(pos_valid), 32'(0));
        check("midrst.lost", 32'(signal_lost), 32'(1));
        check("midrst.busy", 32'(busy), 32'(0));
        reset = 1'b0;
        snap();
        repeat (100) @(negedge clk);
        check("midrst.busy_tail", 32'(busy), 32'(0));
        pwm_in = 1'b0;
        repeat (LAT + 6) @(negedge clk);
        check("midrst.no_valid", 32'(v_cnt - v0), 32'(0));
        check("midrst.no_short", 32'(s_cnt - s0), 32'(0));
        check("midrst.no_long",  32'(l_cnt - l0), 32'(0));
        check("midrst.pos_hold", 32'(pos), 32'(0));
        run(T_BASE + T_STEP * 128, "after_midrst");

`ifdef PWM_GLITCH_FILTER_EN
        // Single-cycle low glitch inside a 128-position pulse
        snap();
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (300) @(negedge clk);
        pwm_in = 1'b0;
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (T_BASE + T_STEP * 128 - 301) @(negedge clk);
        pwm_in   = 1'b0;
        fall_cyc = cyc;
        repeat (LAT + 6) @(negedge clk);
        check_result(T_BASE + T_STEP * 128, "glitch");
`endif

        // Randomized widths across the whole range
        for (int k = 0; k < 16; k++) begin
            run(int'($urandom_range(60, 1500)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
